// File: rtl/mult_ctrl_pkg.sv
// Shared definitions for the shift-add multiplier sequencer: state encodings,
// default geometry and a state classification helper.
package mult_ctrl_pkg;

    localparam int MY_WIDTH_DEF = 9;
    localparam int CNT_W_DEF    = 4;
    localparam int ST_W         = 3;

    localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [ST_W-1:0] ST_LOAD  = 3'd1;
    localparam logic [ST_W-1:0] ST_ADD   = 3'd2;
    localparam logic [ST_W-1:0] ST_SHIFT = 3'd3;
    localparam logic [ST_W-1:0] ST_ADDSH = 3'd4;
    localparam logic [ST_W-1:0] ST_DONE  = 3'd5;

    // States in which an operation is in flight and abort takes effect
    function automatic logic is_running(input logic [ST_W-1:0] st);
        return (st == ST_LOAD) || (st == ST_ADD) || (st == ST_SHIFT) || (st == ST_ADDSH);
    endfunction

endpackage

// File: rtl/mult_iter_counter.sv
// Iteration counter for the multiplier sequencer: synchronous clear, saturating
// increment and terminal-count flag at MY_WIDTH-1.
module mult_iter_counter
    import mult_ctrl_pkg::*;
#(
    parameter int MY_WIDTH = MY_WIDTH_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);

    logic [CNT_W-1:0] cnt_r;
    logic             tc_s;

    assign tc_s = (cnt_r == CNT_W'(MY_WIDTH - 1));

    // Counter register; increment is blocked at terminal count so it never wraps
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (inc && !tc_s) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt = cnt_r;
    assign tc  = tc_s;

endmodule

// File: rtl/mult_seq_ctrl.sv
// Handshaked sequencer for the 16x9 shift-add multiplier datapath.
// Build option MERGE_ADD_SHIFT_EN fuses ADD and SHIFT into a single ADDSH state.
module mult_seq_ctrl
    import mult_ctrl_pkg::*;
#(
    parameter int MY_WIDTH = MY_WIDTH_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             start,
    input  logic             abort,
    input  logic             my_lsb,
    output logic             busy,
    output logic             done,
    output logic             load_Mx,
    output logic             load_My,
    output logic             clr_Acc,
    output logic             load_Acc,
    output logic             shift_My,
    output logic             shift_in,
    output logic [CNT_W-1:0] iter_cnt
);

    logic [ST_W-1:0]  state_r;
    logic [ST_W-1:0]  state_next_s;
    logic             abort_run_s;
    logic             cnt_clr_s;
    logic             cnt_inc_s;
    logic             cnt_tc_s;
    logic [CNT_W-1:0] iter_cnt_s;

    assign abort_run_s = abort && is_running(state_r);
    assign cnt_clr_s   = (state_r == ST_LOAD) || (state_r == ST_DONE) || abort_run_s;
    assign cnt_inc_s   = (state_r == ST_SHIFT) || (state_r == ST_ADDSH);

    mult_iter_counter #(
        .MY_WIDTH (MY_WIDTH),
        .CNT_W    (CNT_W)
    ) u_iter_counter (
        .clk   (CLK),
        .reset (RESET),
        .clr   (cnt_clr_s),
        .inc   (cnt_inc_s),
        .cnt   (iter_cnt_s),
        .tc    (cnt_tc_s)
    );

    // State register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; abort of a running operation overrides every transition
    always_comb begin
        state_next_s = state_r;
        if (abort_run_s) begin
            state_next_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE:  state_next_s = start ? ST_LOAD : ST_IDLE;
`ifdef MERGE_ADD_SHIFT_EN
                ST_LOAD:  state_next_s = ST_ADDSH;
                ST_ADDSH: state_next_s = cnt_tc_s ? ST_DONE : ST_ADDSH;
`else
                ST_LOAD:  state_next_s = ST_ADD;
                ST_ADD:   state_next_s = ST_SHIFT;
                ST_SHIFT: state_next_s = cnt_tc_s ? ST_DONE : ST_ADD;
`endif
                ST_DONE:  state_next_s = ST_IDLE;
                default:  state_next_s = ST_IDLE;
            endcase
        end
    end

    // Moore output decode; my_lsb only qualifies the accumulate strobe
    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        load_Mx  = 1'b0;
        load_My  = 1'b0;
        clr_Acc  = 1'b0;
        load_Acc = 1'b0;
        shift_My = 1'b0;
        shift_in = 1'b0;
        case (state_r)
            ST_IDLE: begin
                busy = 1'b0;
            end
            ST_LOAD: begin
                busy    = 1'b1;
                load_Mx = 1'b1;
                load_My = 1'b1;
                clr_Acc = 1'b1;
            end
`ifdef MERGE_ADD_SHIFT_EN
            ST_ADDSH: begin
                busy     = 1'b1;
                load_Acc = my_lsb;
                shift_My = 1'b1;
                shift_in = 1'b1;
            end
`else
            ST_ADD: begin
                busy     = 1'b1;
                load_Acc = my_lsb;
            end
            ST_SHIFT: begin
                busy     = 1'b1;
                shift_My = 1'b1;
                shift_in = 1'b1;
            end
`endif
            ST_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign iter_cnt = iter_cnt_s;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed self-checking bench for mult_seq_ctrl with a small My shift-register
// model feeding my_lsb. Honours MERGE_ADD_SHIFT_EN for the expected latency.
module tb_mult_seq_ctrl;

    localparam int MYW = 9;
    localparam int CW  = 4;
`ifdef MERGE_ADD_SHIFT_EN
    localparam bit MERGED = 1'b1;
`else
    localparam bit MERGED = 1'b0;
`endif
    localparam int LAT = MERGED ? (MYW + 2) : (2 * MYW + 2);

    logic          CLK = 1'b0;
    logic          RESET;
    logic          start;
    logic          abort;
    logic          my_lsb;
    logic          busy, done, load_Mx, load_My, clr_Acc, load_Acc, shift_My, shift_in;
    logic [CW-1:0] iter_cnt;
    logic [MYW-1:0] my_reg;
    logic [MYW-1:0] pat;
    logic [7:0]    obs;

    int checks   = 0;
    int failures = 0;

    mult_seq_ctrl #(.MY_WIDTH(MYW), .CNT_W(CW)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .start    (start),
        .abort    (abort),
        .my_lsb   (my_lsb),
        .busy     (busy),
        .done     (done),
        .load_Mx  (load_Mx),
        .load_My  (load_My),
        .clr_Acc  (clr_Acc),
        .load_Acc (load_Acc),
        .shift_My (shift_My),
        .shift_in (shift_in),
        .iter_cnt (iter_cnt)
    );

    always #5 CLK = ~CLK;

    assign obs    = {busy, done, load_Mx, load_My, clr_Acc, load_Acc, shift_My, shift_in};
    assign my_lsb = my_reg[0];

    // Multiplier register model driven by the sequencer strobes
    always @(posedge CLK) begin
        if (RESET === 1'b1)         my_reg <= '0;
        else if (load_My === 1'b1)  my_reg <= pat;
        else if (shift_My === 1'b1) my_reg <= {1'b0, my_reg[MYW-1:1]};
    end

    // Per-cycle invariants: strobe exclusivity, paired shift strobes, counter range
    always @(negedge CLK) begin
        if (RESET === 1'b0) begin
            checks++;
            if (((!MERGED) && ((int'(load_Acc) + int'(shift_My) + int'(clr_Acc)) > 1)) ||
                (shift_My !== shift_in) || (iter_cnt > 4'd8) ||
                ((busy === 1'b0) && (obs[6:0] !== 7'd0))) begin
                failures++;
                $display("FAIL invariants: obs=%b iter_cnt=%0d (required exclusive strobes, iter_cnt<=8)",
                         obs, iter_cnt);
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Launches one operation and observes it cycle by cycle (cycle 1 = LOAD)
    task automatic run_op(input logic [MYW-1:0] p, input int abort_iter, input int reset_iter,
                          output int done_cyc, output int n_add, output int n_shift,
                          output logic [MYW-1:0] add_mask, output logic [7:0] first_obs,
                          output logic [7:0] post_obs, output logic [CW-1:0] post_cnt);
        int n;
        bit trig;
        pat = p;
        done_cyc = -1; n_add = 0; n_shift = 0; add_mask = '0;
        post_obs = 8'hFF; post_cnt = 4'hF; trig = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        first_obs = obs;
        n = 1;
        while (n <= 3 * LAT) begin
            if (done === 1'b1 && done_cyc < 0) done_cyc = n;
            if (load_Acc === 1'b1) begin
                n_add++;
                add_mask[iter_cnt] = 1'b1;
            end
            if (shift_My === 1'b1) n_shift++;
            if (busy !== 1'b1) break;
            if (!trig && abort_iter >= 0 && shift_My === 1'b1 && int'(iter_cnt) == abort_iter) begin
                abort = 1'b1; trig = 1'b1;
            end
            if (!trig && reset_iter >= 0 && load_My === 1'b0 && int'(iter_cnt) == reset_iter &&
                (MERGED || shift_My === 1'b0)) begin
                RESET = 1'b1; trig = 1'b1;
            end
            step();
            if (abort || RESET) begin
                post_obs = obs; post_cnt = iter_cnt;
                abort = 1'b0; RESET = 1'b0;
            end
            n++;
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1; start = 1'b1; abort = 1'b0; pat = '0;
        repeat (3) step();
        checks++;
        if (obs !== 8'd0 || iter_cnt !== 4'd0) begin
            failures++;
            $display("FAIL reset_state: obs=%b iter_cnt=%0d required obs=00000000 iter_cnt=0", obs, iter_cnt);
        end
        start = 1'b0; RESET = 1'b0;
        step();
        checks++;
        if (obs !== 8'd0) begin
            failures++;
            $display("FAIL reset_idle: obs=%b required 00000000", obs);
        end
    endtask

    task automatic test_full_run(input logic [MYW-1:0] p, input int exp_add);
        int dc, na, ns;
        logic [MYW-1:0] mask;
        logic [7:0] fo, po;
        logic [CW-1:0] pc;
        run_op(p, -1, -1, dc, na, ns, mask, fo, po, pc);
        checks++;
        if (fo !== 8'b1011_1000) begin
            failures++;
            $display("FAIL load_cycle p=%h: obs=%b required 10111000", p, fo);
        end
        checks++;
        if (dc != LAT) begin
            failures++;
            $display("FAIL done_latency p=%h: cycle=%0d required %0d", p, dc, LAT);
        end
        checks++;
        if (na != exp_add || mask !== p) begin
            failures++;
            $display("FAIL add_pulses p=%h: count=%0d mask=%h required count=%0d mask=%h", p, na, mask, exp_add, p);
        end
        checks++;
        if (ns != MYW) begin
            failures++;
            $display("FAIL shift_pulses p=%h: count=%0d required %0d", p, ns, MYW);
        end
        checks++;
        if (obs !== 8'd0 || iter_cnt !== 4'd0) begin
            failures++;
            $display("FAIL post_done_idle p=%h: obs=%b iter_cnt=%0d required 0/0", p, obs, iter_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int n, loads, second, dc;
        logic busy_gap;
        pat = 9'h1A5; loads = 0; second = -1; dc = -1; busy_gap = 1'b1;
        start = 1'b1;
        step();
        for (n = 1; n <= LAT + 3; n++) begin
            if (load_My === 1'b1) begin
                loads++;
                if (n > 1 && second < 0) second = n;
            end
            if (done === 1'b1 && dc < 0) dc = n;
            if (n == LAT + 1) busy_gap = busy;
            step();
        end
        start = 1'b0;
        checks++;
        if (dc != LAT || busy_gap !== 1'b0) begin
            failures++;
            $display("FAIL b2b_first: done_cycle=%0d busy_in_gap=%b required %0d/0", dc, busy_gap, LAT);
        end
        checks++;
        if (loads != 2 || second != LAT + 2) begin
            failures++;
            $display("FAIL b2b_second_load: loads=%0d second=%0d required 2/%0d", loads, second, LAT + 2);
        end
        n = 0;
        while (busy === 1'b1 && n < 3 * LAT) begin
            step();
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_drain: busy=%b required 0 within %0d cycles", busy, 3 * LAT);
        end
    endtask

    task automatic test_abort();
        int dc, na, ns;
        logic [MYW-1:0] mask;
        logic [7:0] fo, po;
        logic [CW-1:0] pc;
        run_op(9'h1A5, 4, -1, dc, na, ns, mask, fo, po, pc);
        checks++;
        if (po !== 8'd0 || pc !== 4'd0) begin
            failures++;
            $display("FAIL abort_state: obs=%b iter_cnt=%0d required 00000000/0", po, pc);
        end
        checks++;
        if (dc != -1 || ns != 5) begin
            failures++;
            $display("FAIL abort_no_done: done_cycle=%0d shifts=%0d required -1/5", dc, ns);
        end
    endtask

    task automatic test_mid_reset();
        int dc, na, ns;
        logic [MYW-1:0] mask;
        logic [7:0] fo, po;
        logic [CW-1:0] pc;
        run_op(9'h1A5, -1, 6, dc, na, ns, mask, fo, po, pc);
        checks++;
        if (po !== 8'd0 || pc !== 4'd0) begin
            failures++;
            $display("FAIL midreset_state: obs=%b iter_cnt=%0d required 00000000/0", po, pc);
        end
        checks++;
        if (dc != -1) begin
            failures++;
            $display("FAIL midreset_no_done: done_cycle=%0d required -1", dc);
        end
    endtask

    initial begin
        test_reset();
        test_full_run(9'h1A5, 5);
        test_full_run(9'h000, 0);
        test_full_run(9'h1FF, 9);
        test_back_to_back();
        test_abort();
        test_mid_reset();
        test_full_run(9'h100, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
